// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared scan state type, blank segment code and hex glyph decoder
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Segment order {g,f,e,d,c,b,a}, lit = 1 before polarity is applied
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_btn_debounce.sv
// rtl/seg_btn_debounce.sv - button synchroniser, stability counter and debounced rising-edge pulse
module seg_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive synchronised samples that disagree with the accepted level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - multiplexed seven-segment scan driver with blanking and freeze
// Optional per-slot duty dimming when DISP_BRIGHTNESS_EN is defined.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int N_DIGITS        = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int BLANK_CYCLES    = 500,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SEG_ACTIVE_LOW  = 0,
  parameter int AN_ACTIVE_LOW   = 0,
  parameter int BRIGHT_W        = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn,
  input  logic [4*N_DIGITS-1:0]       data_i,
  input  logic [N_DIGITS-1:0]         digit_en_i,
`ifdef DISP_BRIGHTNESS_EN
  input  logic [BRIGHT_W-1:0]         brightness_i,
`endif
  output logic [6:0]                  seg_o,
  output logic [N_DIGITS-1:0]         an_o,
  output logic                        frozen_o,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx_o
);

  localparam int   IDX_W   = $clog2(N_DIGITS);
  localparam int   PRE_W   = $clog2(REFRESH_DIV);
  localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  scan_state_t           state_q, state_d;
  logic [4*N_DIGITS-1:0] snap_nib_q, snap_nib_d;
  logic [N_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic                  frozen_q, frozen_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  presc_wrap, snap_take, lit, btn_rise;
  logic [BRIGHT_W-1:0]   show_ofs;
  logic [BRIGHT_W:0]     duty_lim;

  seg_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn),
    .rise_o (btn_rise)
  );

`ifdef DISP_BRIGHTNESS_EN
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  assign duty_lim = {1'b0, bright_q};
`else
  // Full-scale limit: every offset passes, so the anode stays on through SHOW
  assign duty_lim = {1'b1, {BRIGHT_W{1'b0}}};
`endif

  always_comb begin
    presc_wrap = (presc_q == PRE_W'(REFRESH_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + PRE_W'(1);
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    state_d = (presc_d < PRE_W'(BLANK_CYCLES)) ? BLANK : SHOW;

    // Tear-free capture: one nibble per slot, taken on the slot's first blank cycle
    snap_take  = (state_q == BLANK) && (presc_q == '0) && !frozen_q;
    snap_nib_d = snap_nib_q;
    snap_en_d  = snap_en_q;
`ifdef DISP_BRIGHTNESS_EN
    bright_d = bright_q;
    if (snap_take) bright_d = brightness_i;
`endif
    if (snap_take) begin
      snap_nib_d[{idx_q, 2'b00} +: 4] = data_i[{idx_q, 2'b00} +: 4];
      snap_en_d[idx_q]                = digit_en_i[idx_q];
    end
    frozen_d = frozen_q ^ btn_rise;

    show_ofs = BRIGHT_W'(presc_q) - BRIGHT_W'(BLANK_CYCLES);
    lit      = ({1'b0, show_ofs} < duty_lim);
    an_d     = '0;
    seg_d    = SEG_OFF;
    if (state_q == SHOW) begin
      an_d[idx_q] = lit;
      if (snap_en_q[idx_q]) seg_d = hex_to_seg(snap_nib_q[{idx_q, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      state_q    <= BLANK;
      snap_nib_q <= '0;
      snap_en_q  <= '0;
      frozen_q   <= 1'b0;
      an_q       <= {N_DIGITS{AN_POL}};
      seg_q      <= {7{SEG_POL}};
`ifdef DISP_BRIGHTNESS_EN
      bright_q   <= '0;
`endif
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      snap_nib_q <= snap_nib_d;
      snap_en_q  <= snap_en_d;
      frozen_q   <= frozen_d;
      an_q       <= an_d ^ {N_DIGITS{AN_POL}};
      seg_q      <= seg_d ^ {7{SEG_POL}};
`ifdef DISP_BRIGHTNESS_EN
      bright_q   <= bright_d;
`endif
    end
  end

  assign seg_o       = seg_q;
  assign an_o        = an_q;
  assign frozen_o    = frozen_q;
  assign digit_idx_o = idx_q;

endmodule
